// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4-input nibble mux.
// Define MUXARB_FIXED_PRI_EN for fixed priority a > b > c > d.
module mux_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] z,
    output logic       z_vld
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_MAX);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] start;
    logic [2:0] win;
    logic [3:0] data;
    logic       owner_req;
    logic       release_now;

`ifdef MUXARB_FIXED_PRI_EN
    assign start = 2'd0;
`else
    logic [1:0] last;
    assign start = last + 2'd1;
`endif

    // {found, index}: first set bit scanning upward from s with wrap
    function automatic logic [2:0] pick(
        input logic [3:0] r,
        input logic [1:0] s
    );
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = s + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign win = pick(req, start);

    always_comb begin
        data = 4'b0000;
        if (!en) begin
            unique case (sel)
                2'd0: data = a;
                2'd1: data = b;
                2'd2: data = c;
                2'd3: data = d;
            endcase
        end
    end

    assign owner_req   = req[sel];
    assign release_now = !owner_req || (cnt == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            en    <= 1'b1;
            z     <= 4'b0000;
            z_vld <= 1'b0;
            cnt   <= 4'd0;
`ifndef MUXARB_FIXED_PRI_EN
            last  <= 2'd3;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    z_vld <= 1'b0;
                    if (win[2]) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << win[1:0];
                        sel   <= win[1:0];
                        en    <= 1'b0;
                        cnt   <= 4'd1;
`ifndef MUXARB_FIXED_PRI_EN
                        last  <= win[1:0];
`endif
                    end
                end
                GRANT: begin
                    z_vld <= owner_req;
                    if (owner_req) z <= data;
                    if (release_now) begin
                        // a lone owner at its limit wins its own re-search
                        if (win[2]) begin
                            gnt  <= 4'b0001 << win[1:0];
                            sel  <= win[1:0];
                            cnt  <= 4'd1;
`ifndef MUXARB_FIXED_PRI_EN
                            last <= win[1:0];
`endif
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                            en    <= 1'b1;
                            cnt   <= 4'd0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: spec-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_mux_arbiter;

    localparam int HM = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic [3:0] z;
    logic       z_vld;

    int n_assert = 0;
    int n_fail   = 0;

    mux_arbiter #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .sel(sel), .en(en),
        .z(z), .z_vld(z_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Model: owner index (-1 = idle), tenure length, rr pointer
    int         m_own;
    int         m_cnt;
    int         m_last;
    int         m_sel;
    int         m_w;
    logic [3:0] m_z;
    logic       m_zv;
    bit         m_known = 0;

    function automatic logic [3:0] din(input int i);
        case (i)
            0: return a;
            1: return b;
            2: return c;
            default: return d;
        endcase
    endfunction

    function automatic int find(input logic [3:0] r, input int lst);
        int s;
`ifdef MUXARB_FIXED_PRI_EN
        s = 0;
`else
        s = (lst + 1) % 4;
`endif
        for (int k = 0; k < 4; k++)
            if (r[(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_own = -1; m_cnt = 0; m_last = 3; m_sel = 0;
            m_z = 4'h0; m_zv = 1'b0; m_known = 1;
        end else if (m_own < 0) begin
            m_zv = 1'b0;
            m_w = find(req, m_last);
            if (m_w >= 0) begin
                m_own = m_w; m_sel = m_w; m_cnt = 1; m_last = m_w;
            end
        end else begin
            m_zv = req[m_own];
            if (req[m_own]) m_z = din(m_own);
            if (!req[m_own] || m_cnt == HM) begin
                m_w = find(req, m_last);
                m_own = m_w;
                if (m_w >= 0) begin
                    m_sel = m_w; m_cnt = 1; m_last = m_w;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        #1;
        if (m_known) begin
            chk("m_gnt", gnt, (m_own < 0) ? 4'b0000 : 4'(1 << m_own));
            chk("m_sel", {2'b00, sel}, 4'(m_sel));
            chk("m_en", {3'b000, en}, {3'b000, (m_own < 0)});
            chk("m_z", z, m_z);
            chk("m_zvld", {3'b000, z_vld}, {3'b000, m_zv});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_pulse();
        rst = 1'b1; req = 4'b0000;
        step(1);
        rst = 1'b0;
    endtask

    logic [3:0] tab_req [8];
    int         tab_len [8];

    initial begin
        rst = 1'b1; req = 4'b0000;
        a = 4'h0; b = 4'h0; c = 4'h0; d = 4'h0;
        tab_req = '{4'b1111, 4'b0110, 4'b1000, 4'b0000,
                    4'b1010, 4'b0011, 4'b1101, 4'b0100};
        tab_len = '{9, 6, 3, 2, 11, 5, 13, 4};

        // reset then idle
        step(2);
        rst = 1'b0;
        step(3);
        chk("idle_gnt", gnt, 4'b0000);
        chk("idle_en", {3'b000, en}, 4'h1);
        chk("idle_sel", {2'b00, sel}, 4'h0);
        chk("idle_z", z, 4'h0);
        chk("idle_zvld", {3'b000, z_vld}, 4'h0);

        // single requester b
        req = 4'b0010; b = 4'h9;
        step(1);
        chk("single_gnt", gnt, 4'b0010);
        chk("single_sel", {2'b00, sel}, 4'h1);
        chk("single_zvld0", {3'b000, z_vld}, 4'h0);
        step(1);
        chk("single_z", z, 4'h9);
        step(4);
        chk("single_regnt", gnt, 4'b0010);
        chk("single_nogap", {3'b000, z_vld}, 4'h1);
        req = 4'b0000;
        step(2);

`ifndef MUXARB_FIXED_PRI_EN
        // round robin a <-> c
        rst_pulse();
        req = 4'b0101; a = 4'h1; c = 4'h3;
        step(1);
        chk("rr_first", gnt, 4'b0001);
        step(4);
        chk("rr_hand", gnt, 4'b0100);
        chk("rr_z_a", z, 4'h1);
        step(1);
        chk("rr_z_c", z, 4'h3);
        chk("rr_nobub", {3'b000, z_vld}, 4'h1);
        step(3);
        chk("rr_back", gnt, 4'b0001);
`endif

        // early release a -> d
        rst_pulse();
        req = 4'b1001; a = 4'h5; d = 4'h7;
        step(2);
        chk("early_z_a", z, 4'h5);
        req = 4'b1000;
        step(1);
        chk("early_gnt", gnt, 4'b1000);
        chk("early_sel", {2'b00, sel}, 4'h3);
        chk("early_zvld", {3'b000, z_vld}, 4'h0);
        step(1);
        chk("early_z_d", z, 4'h7);
        chk("early_zvld1", {3'b000, z_vld}, 4'h1);

        // reset mid-grant of c
        rst_pulse();
        req = 4'b0100; c = 4'hc;
        step(2);
        rst = 1'b1; req = 4'b1111;
        step(1);
        chk("mrst_gnt", gnt, 4'b0000);
        chk("mrst_en", {3'b000, en}, 4'h1);
        chk("mrst_zvld", {3'b000, z_vld}, 4'h0);
        rst = 1'b0;
        step(1);
        chk("mrst_a", gnt, 4'b0001);

`ifdef MUXARB_FIXED_PRI_EN
        rst_pulse();
        req = 4'b1001; a = 4'h2; d = 4'he;
        step(1);
        chk("fp_a1", gnt, 4'b0001);
        step(4);
        chk("fp_a2", gnt, 4'b0001);
        chk("fp_nogap", {3'b000, z_vld}, 4'h1);
        step(4);
        chk("fp_a3", gnt, 4'b0001);
`endif

        // directed request table with changing data
        for (int t = 0; t < 8; t++) begin
            req = tab_req[t];
            for (int k = 0; k < tab_len[t]; k++) begin
                a = 4'(t + k);
                b = 4'(~(t + k));
                c = 4'(t * 3 + k + 5);
                d = 4'(k) ^ 4'ha;
                step(1);
            end
        end
        req = 4'b0000;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
